// File: rtl/snn_cfg_loader.sv
`timescale 1ns/1ps
// snn_cfg_loader: SPI (mode 0, MSB first) configuration loader.
// SPI pins are oversampled in the clk domain. Bytes are written into a staging
// bank, which is copied atomically into the active bank (cfg_data) when a frame
// that requested a commit ends. The active bank can be read back over MISO.
module snn_cfg_loader #(
  parameter int DEPTH       = 215,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss_n,
  output logic                 miso,
  output logic [DEPTH*8-1:0]   cfg_data,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 addr_err
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [15:0] LAST_A  = 16'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR_HI = 3'd2,
    S_ADDR_LO = 3'd3,
    S_DATA    = 3'd4,
    S_IGNORE  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic [SYNC_STAGES:0]   arm_sh;
  logic                   sclk_s, mosi_s, ss_s, armed;
  logic                   sclk_d, ss_d;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0]             shreg;
  logic [2:0]             bit_cnt;
  logic                   byte_done;
  state_t                 state, state_n;
  logic                   wr_flag, commit_flag;
  logic [7:0]             addr_hi;
  logic [15:0]            addr, addr_inc, new_addr;
  logic                   addr_ok;
  logic                   we, rd_load, rd_shift, commit;
  logic [7:0]             oshift;
  logic [7:0]             staging      [DEPTH];
  logic [7:0]             staging_next [DEPTH];
  logic [7:0]             active       [DEPTH];

  // Synchronizer chains. ss_n resets to "deselected"; the arm shifter keeps all
  // strobes off until the chains have refilled, so a frame that was running
  // across a reset is never picked up half-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      arm_sh    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      arm_sh    <= {arm_sh[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign armed  = arm_sh[SYNC_STAGES];

  // Edge-detect registers for sclk and ss_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  assign ss_fall   = armed & ~ss_s & ss_d;
  assign ss_rise   = armed & ss_s & ~ss_d;
  assign sclk_rise = armed & ~ss_s & sclk_s & ~sclk_d;
  assign sclk_fall = armed & ~ss_s & ~sclk_s & sclk_d;

  // Input shift register and bit counter; byte_done pulses when the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= 8'd0;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_fall) begin
        shreg   <= 8'd0;
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg     <= {shreg[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  assign new_addr = {addr_hi, shreg};
  assign addr_ok  = ({1'b0, new_addr} < DEPTH_L);
  assign addr_inc = (addr == LAST_A) ? 16'd0 : addr + 16'd1;
  assign we       = (state == S_DATA) & wr_flag & byte_done;
  assign rd_load  = (state == S_DATA) & ~wr_flag & sclk_fall & (bit_cnt == 3'd0);
  assign rd_shift = (state == S_DATA) & ~wr_flag & sclk_fall & (bit_cnt != 3'd0);
  // A commit request latched in the same cycle as the frame end still counts.
  assign commit   = ss_rise & (commit_flag | ((state == S_CMD) & byte_done & shreg[6]));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic; ss_n rise returns to IDLE from any state.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (ss_fall)   state_n = S_CMD;     else state_n = S_IDLE;
      S_CMD:     if (byte_done) state_n = S_ADDR_HI; else state_n = S_CMD;
      S_ADDR_HI: if (byte_done) state_n = S_ADDR_LO; else state_n = S_ADDR_HI;
      S_ADDR_LO: begin
        if (byte_done) begin
          if (addr_ok) state_n = S_DATA;
          else         state_n = S_IGNORE;
        end else begin
          state_n = S_ADDR_LO;
        end
      end
      S_DATA:    state_n = S_DATA;
      S_IGNORE:  state_n = S_IGNORE;
      default:   state_n = S_IDLE;
    endcase
    if (ss_rise) begin
      state_n = S_IDLE;
    end else begin
      state_n = state_n;
    end
  end

  // Frame control: command flags, address pointer and address error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_flag     <= 1'b0;
      commit_flag <= 1'b0;
      addr_hi     <= 8'd0;
      addr        <= 16'd0;
      addr_err    <= 1'b0;
    end else if (ss_fall) begin
      wr_flag     <= 1'b0;
      commit_flag <= 1'b0;
      addr_hi     <= 8'd0;
      addr        <= 16'd0;
      addr_err    <= 1'b0;
    end else begin
      if (byte_done) begin
        case (state)
          S_CMD: begin
            wr_flag     <= shreg[7];
            commit_flag <= shreg[6];
          end
          S_ADDR_HI: addr_hi <= shreg;
          S_ADDR_LO: begin
            addr     <= new_addr;
            addr_err <= ~addr_ok;
          end
          default: ;
        endcase
      end
      if (we || rd_load) begin
        addr <= addr_inc;
      end
    end
  end

  // Staging image with the current write merged in, so a commit in the same
  // cycle as a final byte still captures that byte.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      staging_next[k] = (we && (addr == 16'(k))) ? shreg : staging[k];
    end
  end

  // Staging and active banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        staging[k] <= 8'd0;
        active[k]  <= 8'd0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        staging[k] <= staging_next[k];
        if (commit) begin
          active[k] <= staging_next[k];
        end
      end
    end
  end

  // Readback shifter: load a byte at the first fall of each byte, else shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oshift <= 8'd0;
    end else if (ss_fall) begin
      oshift <= 8'd0;
    end else if (rd_load) begin
      oshift <= active[addr[IW-1:0]];
    end else if (rd_shift) begin
      oshift <= {oshift[6:0], 1'b0};
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      miso      <= ((state == S_DATA) && !wr_flag) ? oshift[7] : 1'b0;
      cfg_valid <= commit;
      busy      <= ~ss_s;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gen_out
    assign cfg_data[8*k +: 8] = active[k];
  end

endmodule

// File: tb/tb_snn_cfg_loader.sv
`timescale 1ns/1ps
// Self-checking bench for snn_cfg_loader: drives SPI frames, keeps a model of
// the staging/active banks and a queue of expected readback bytes.
module tb_snn_cfg_loader;

  localparam int DEPTH = 215;
  localparam int SYNC  = 2;
  localparam int HALF  = 80;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sclk = 1'b0;
  logic               mosi = 1'b0;
  logic               ss_n = 1'b1;
  logic               miso;
  logic [DEPTH*8-1:0] cfg_data;
  logic               cfg_valid;
  logic               busy;
  logic               addr_err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_stage  [DEPTH];
  logic [7:0] model_active [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] tx_data [8];
  int         v_high = 0;
  int         v_edge = 0;
  logic       v_prev = 1'b0;

  snn_cfg_loader #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .miso      (miso),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  // Count cfg_valid high cycles and rising edges.
  always @(negedge clk) begin
    if (cfg_valid) v_high <= v_high + 1;
    if (cfg_valid && !v_prev) v_edge <= v_edge + 1;
    v_prev <= cfg_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      check_eq($sformatf("%s[%0d]", tag, k), {24'd0, cfg_data[8*k +: 8]}, {24'd0, model_active[k]});
    end
  endtask

  // Send the top nb bits of v MSB first; sample miso just before each rise.
  task automatic spi_bits(input logic [7:0] v, input int nb, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nb; i++) begin
      mosi = v[7-i];
      #(HALF);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [15:0] fa, input int n, input int tail);
    logic [7:0] rx;
    logic [7:0] exp_b;
    logic       err;
    int         a;
    int         h0;
    int         e0;
    err = (fa >= 16'(DEPTH));
    a   = int'(fa);
    h0  = v_high;
    e0  = v_edge;
    ss_n = 1'b0;
    #(HALF);
    check_eq("busy_on", {31'd0, busy}, 32'd1);
    check_eq("err_clear", {31'd0, addr_err}, 32'd0);
    spi_bits(cmd, 8, rx);
    spi_bits(fa[15:8], 8, rx);
    spi_bits(fa[7:0], 8, rx);
    for (int i = 0; i < n; i++) begin
      if (!err && !cmd[7]) exp_q.push_back(model_active[a]);
      spi_bits(tx_data[i], 8, rx);
      if (!err) begin
        if (cmd[7]) begin
          model_stage[a] = tx_data[i];
        end else begin
          exp_b = exp_q.pop_front();
          check_eq("miso_byte", {24'd0, rx}, {24'd0, exp_b});
        end
        a = (a == DEPTH - 1) ? 0 : a + 1;
      end
    end
    if (tail > 0) spi_bits(8'hFF, tail, rx);
    mosi = 1'b0;
    #(HALF);
    ss_n = 1'b1;
    #(200);
    if (cmd[6]) begin
      for (int k = 0; k < DEPTH; k++) model_active[k] = model_stage[k];
    end
    check_eq("valid_pulses", 32'(v_edge - e0), {31'd0, cmd[6]});
    check_eq("valid_cycles", 32'(v_high - h0), {31'd0, cmd[6]});
    check_eq("addr_err", {31'd0, addr_err}, {31'd0, err});
    check_eq("busy_off", {31'd0, busy}, 32'd0);
    check_eq("miso_idle", {31'd0, miso}, 32'd0);
    check_bank("bank");
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int h0;
    int e0;
    for (int k = 0; k < DEPTH; k++) begin
      model_stage[k]  = 8'd0;
      model_active[k] = 8'd0;
    end
    #20;
    check_eq("rst_valid", {31'd0, cfg_valid}, 32'd0);
    check_eq("rst_miso", {31'd0, miso}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, addr_err}, 32'd0);
    check_bank("rst_bank");
    #10 rst_n = 1'b1;
    #100;

    // Write + commit three bytes at address 0.
    tx_data[0] = 8'hA5; tx_data[1] = 8'h3C; tx_data[2] = 8'h0F;
    do_frame(8'hC0, 16'h0000, 3, 0);
    // Write without commit, then commit-only frame.
    tx_data[0] = 8'h77;
    do_frame(8'h80, 16'h0005, 1, 0);
    do_frame(8'h40, 16'h0000, 0, 0);
    // Readback of the first three bytes, no commit.
    do_frame(8'h00, 16'h0000, 3, 0);
    // Address wrap on write.
    tx_data[0] = 8'h11; tx_data[1] = 8'h22;
    do_frame(8'hC0, 16'(DEPTH - 1), 2, 0);
    // Out-of-range address: error, commit of unchanged staging.
    tx_data[0] = 8'hFF;
    do_frame(8'hC0, 16'(DEPTH), 1, 0);
    // High address byte out of range, no commit.
    do_frame(8'h80, 16'h0100, 1, 0);
    // Readback across the wrap point, with commit.
    do_frame(8'h40, 16'(DEPTH - 2), 3, 0);
    // Partial 5-bit tail is discarded.
    tx_data[0] = 8'h55;
    do_frame(8'hC0, 16'd10, 1, 5);

    // Reset in the middle of a write after 1.5 data bytes.
    ss_n = 1'b0;
    #(HALF);
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h12, 8, rx);
    spi_bits(8'h34, 4, rx);
    rst_n = 1'b0;
    #30;
    for (int k = 0; k < DEPTH; k++) begin
      model_stage[k]  = 8'd0;
      model_active[k] = 8'd0;
    end
    check_eq("mid_rst_valid", {31'd0, cfg_valid}, 32'd0);
    check_eq("mid_rst_miso", {31'd0, miso}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_err", {31'd0, addr_err}, 32'd0);
    check_bank("mid_rst_bank");
    #20 rst_n = 1'b1;
    #100;
    h0 = v_high;
    e0 = v_edge;
    // Tail of the aborted frame, with no new ss_n fall.
    spi_bits(8'h40, 4, rx);
    spi_bits(8'h56, 8, rx);
    spi_bits(8'hFF, 5, rx);
    mosi = 1'b0;
    #(HALF);
    ss_n = 1'b1;
    #(200);
    check_eq("abort_valid", 32'(v_high - h0), 32'd0);
    check_eq("abort_err", {31'd0, addr_err}, 32'd0);
    check_bank("abort_bank");
    // Commit-only frame: staging must have been cleared by the reset.
    do_frame(8'h40, 16'h0000, 0, 0);
    do_frame(8'h00, 16'h0000, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
